pulse_train_gen: RTL and testbench
==================================

Name: pulse_train_gen

Overview:
- Multi-channel successor to the single-channel step pulse generator. Drives NUM_CH step outputs (one per plotter axis/motor) from a single trigger.
- Pulse width is shared across channels; each channel has its own pulse count.
- Two modes:
  - Independent: each channel emits its pulses back-to-back from slot 0.
  - Synchronized: each channel's pulses are spread evenly over the run of the longest channel, Bresenham style, for straight-line multi-axis moves.

Parameters:
- NUM_CH, 2, number of output channels (>=1).
- PULSE_NUM_BITS, 16, width of each channel's pulse count.
- PULSE_WIDTH_BITS, 8, width of the pulse high-time field, in clk_en ticks.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- clk_en  input  1  tick enable; all state advances only on clk edges with clk_en=1.
- pulse_num  input  NUM_CH*PULSE_NUM_BITS  per-channel pulse counts; channel c occupies bits [c*PULSE_NUM_BITS +: PULSE_NUM_BITS].
- pulse_width  input  PULSE_WIDTH_BITS  high time W per pulse; slot length is 2W ticks.
- mode  input  1  0 = independent, 1 = synchronized; sampled with trigger.
- trigger  input  1  start request.
- out  output  NUM_CH  step pulses.
- done  output  1  last run finished.
- rdy  output  1  ready to accept a trigger.

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE; all counters, accumulators and latched inputs clear.
  - out=0, done=0, rdy=1 immediately, including mid-run.
- Acceptance: on a clk edge with clk_en & rdy & trigger.
  - Latch pulse_num[*], pulse_width and mode.
  - Compute N = max over c of pulse_num[c] (registered).
  - Clear the slot counter s, the tick counter t and the accumulators acc[c].
  - Enter RUN and drop done and rdy from the next cycle.
- States and transitions:
  - IDLE: rdy=1, done=0. Goes to RUN on acceptance.
  - RUN: rdy=0, done=0.
    - Trigger is ignored.
    - After the last tick of slot N-1, goes to DONE.
  - DONE: rdy=1, done=1 (held level). Goes to RUN on acceptance.
- Zero run: if latched W=0 or N=0, go to DONE on the first clk_en tick after acceptance. out stays 0.
- Slot timing:
  - t counts 0..2W-1 per slot (counter width PULSE_WIDTH_BITS+1). At t=2W-1, t wraps to 0 and s increments.
  - The first slot's first tick is the cycle following acceptance.
- Fire decision: registered per channel fire[c], computed for slot s before slot s begins (at acceptance for s=0, at each slot wrap after that).
  - Mode 0: fire[c] = (s < k_c), where k_c is the latched count for channel c.
  - Mode 1: a = acc[c] + k_c, using PULSE_NUM_BITS+1 bits.
    - If a >= N: fire[c]=1 and acc[c] <= a - N.
    - Otherwise: fire[c]=0 and acc[c] <= a.
    - acc starts at 0 for each run.
    - Every channel emits exactly k_c pulses within N slots.
- Output: out[c] = fire[c] & (t < W) & (state==RUN). This is combinational from registers, with no glitch path from inputs.
- Run length: exactly 2*W*N clk_en ticks.
- clk_en=0: all state, counters and outputs hold.
- A trigger coincident with the final tick of RUN is not accepted, because rdy=0 in that cycle.
- Changing input values while in RUN has no effect.

Test Plan:
- NUM_CH=2, W=2, mode 0, counts (3,1):
  - out[0] = 1100 1100 1100 over 12 ticks.
  - out[1] = 1100 0000 0000.
  - done rises after tick 12; rdy=1 at the same time.
- W=1, mode 1, counts (4,2): out[0] fires in slots 0,1,2,3; out[1] fires in slots 1,3. Each channel has exactly 4 and 2 rising edges; run is 8 ticks.
- Mode 1, counts (5,3), W=1: out[1] fires in slots 1,3,4. Check 3 pulses total; done after 10 ticks.
- Counts (0,0), W=3, trigger: out stays 0; done=1 one tick after acceptance. Repeat with counts (4,4), W=0: same result.
- Trigger pulsed mid-run with new counts: ignored, and the run completes with the original pattern. Trigger in DONE: accepted, done drops next cycle.
- clk_en high every 3rd cycle: waveform is identical in ticks to the continuous case.
- Reset asserted mid-pulse, asynchronously between edges: out=0, rdy=1, done=0 immediately, before the next edge.

Source files
------------

// File: rtl/pulse_train_gen_if.sv
// Control and step-output bundle for the multi-channel pulse train generator.
interface pulse_train_gen_if #(
    parameter int unsigned NUM_CH           = 2,
    parameter int unsigned PULSE_NUM_BITS   = 16,
    parameter int unsigned PULSE_WIDTH_BITS = 8
);
    logic                               clk_en;
    logic [NUM_CH*PULSE_NUM_BITS-1:0]   pulse_num;
    logic [PULSE_WIDTH_BITS-1:0]        pulse_width;
    logic                               mode;
    logic                               trigger;
    logic [NUM_CH-1:0]                  out;
    logic                               done;
    logic                               rdy;

    modport master (
        output clk_en, pulse_num, pulse_width, mode, trigger,
        input  out, done, rdy
    );

    modport slave (
        input  clk_en, pulse_num, pulse_width, mode, trigger,
        output out, done, rdy
    );
endinterface

// File: rtl/pulse_train_gen.sv
// Multi-channel step pulse generator: independent back-to-back trains or
// Bresenham-spread trains over the longest channel's run.
module pulse_train_gen #(
    parameter int unsigned NUM_CH           = 2,
    parameter int unsigned PULSE_NUM_BITS   = 16,
    parameter int unsigned PULSE_WIDTH_BITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    pulse_train_gen_if.slave   bus
);
    localparam int unsigned NB = PULSE_NUM_BITS;
    localparam int unsigned WB = PULSE_WIDTH_BITS;
    localparam int unsigned TB = PULSE_WIDTH_BITS + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e                      state_q, state_d;
    logic [NUM_CH-1:0][NB-1:0]   k_q, k_d;
    logic [NUM_CH-1:0][NB-1:0]   acc_q, acc_d;
    logic [NUM_CH-1:0]           fire_q, fire_d;
    logic [NB-1:0]               n_q, n_d;
    logic [NB-1:0]               s_q, s_d;
    logic [TB-1:0]               t_q, t_d;
    logic [WB-1:0]               w_q, w_d;
    logic                        mode_q, mode_d;
    logic [NB-1:0]               n_in;
    logic [TB-1:0]               t_last;
    logic [NB:0]                 step;

    // Fire decision for one channel and one slot; returns {fire, next acc}.
    function automatic logic [NB:0] fire_step(input logic md, input logic [NB-1:0] k,
                                              input logic [NB-1:0] acc, input logic [NB-1:0] n,
                                              input logic [NB-1:0] slot);
        logic [NB:0] a;
        a = {1'b0, acc} + {1'b0, k};
        if (md) begin
            if (a >= {1'b0, n}) return {1'b1, NB'(a - {1'b0, n})};
            return {1'b0, a[NB-1:0]};
        end
        return {slot < k, acc};
    endfunction

    // Longest requested channel run, evaluated on the live inputs for acceptance.
    always_comb begin
        n_in = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.pulse_num[c*NB +: NB] > n_in) n_in = bus.pulse_num[c*NB +: NB];
        end
    end

    assign t_last = {w_q, 1'b0} - TB'(1);

    // Next-state, counters, accumulators and per-slot fire decisions.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        fire_d  = fire_q;
        n_d     = n_q;
        s_d     = s_q;
        t_d     = t_q;
        w_d     = w_q;
        mode_d  = mode_q;
        step    = '0;
        if (bus.clk_en) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.trigger) begin
                        state_d = S_RUN;
                        w_d     = bus.pulse_width;
                        mode_d  = bus.mode;
                        n_d     = n_in;
                        s_d     = '0;
                        t_d     = '0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            k_d[c]    = bus.pulse_num[c*NB +: NB];
                            step      = fire_step(bus.mode, k_d[c], '0, n_in, '0);
                            fire_d[c] = step[NB];
                            acc_d[c]  = step[NB-1:0];
                        end
                    end
                end
                S_RUN: begin
                    if (w_q == '0 || n_q == '0) begin
                        state_d = S_DONE;
                    end else if (t_q == t_last) begin
                        t_d = '0;
                        if (s_q == n_q - NB'(1)) begin
                            state_d = S_DONE;
                        end else begin
                            s_d = s_q + NB'(1);
                            for (int c = 0; c < NUM_CH; c++) begin
                                step      = fire_step(mode_q, k_q[c], acc_q[c], n_q, s_d);
                                fire_d[c] = step[NB];
                                acc_d[c]  = step[NB-1:0];
                            end
                        end
                    end else begin
                        t_d = t_q + TB'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            fire_q  <= '0;
            n_q     <= '0;
            s_q     <= '0;
            t_q     <= '0;
            w_q     <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            fire_q  <= fire_d;
            n_q     <= n_d;
            s_q     <= s_d;
            t_q     <= t_d;
            w_q     <= w_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.out  = fire_q & {NUM_CH{(t_q < TB'(w_q)) && (state_q == S_RUN)}};
    assign bus.rdy  = (state_q != S_RUN);
    assign bus.done = (state_q == S_DONE);
endmodule

// File: tb/tb_pulse_train_gen.sv
// Table-driven bench for pulse_train_gen with a per-tick expected-value queue.
module tb_pulse_train_gen;
    logic clk = 1'b0;
    logic reset;

    pulse_train_gen_if #(.NUM_CH(2), .PULSE_NUM_BITS(16), .PULSE_WIDTH_BITS(8)) bus ();

    pulse_train_gen #(.NUM_CH(2), .PULSE_NUM_BITS(16), .PULSE_WIDTH_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [15:0]  k0;
        logic [15:0]  k1;
        logic [7:0]   w;
        logic         md;
        int           len;
        logic [31:0]  p0;
        logic [31:0]  p1;
    } vec_t;

    typedef struct {
        string       name;
        logic [3:0]  v;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    // Sample {out[1], out[0], done, rdy}.
    function automatic logic [3:0] sample();
        return {bus.out, bus.done, bus.rdy};
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got {out,done,rdy}=%b expected %b", name, got, exp);
        end
    endtask

    task automatic push_and_check(input string name, input logic [3:0] exp);
        exp_t e;
        e.name = name;
        e.v    = exp;
        sb.push_back(e);
        e = sb.pop_front();
        check(e.name, sample(), e.v);
    endtask

    task automatic set_vec(input int i, input string n, input logic [15:0] k0, input logic [15:0] k1,
                           input logic [7:0] w, input logic md, input int len,
                           input logic [31:0] p0, input logic [31:0] p1);
        vecs[i].name = n; vecs[i].k0 = k0; vecs[i].k1 = k1; vecs[i].w = w;
        vecs[i].md = md; vecs[i].len = len; vecs[i].p0 = p0; vecs[i].p1 = p1;
    endtask

    // Starts right after a negedge; accepts the vector, then checks every tick.
    task automatic run_vec(input int idx, input int period, input bit trig_mid);
        vec_t v;
        logic [3:0] e;
        v = vecs[idx];
        bus.pulse_num   = {v.k1, v.k0};
        bus.pulse_width = v.w;
        bus.mode        = v.md;
        bus.trigger     = 1'b1;
        bus.clk_en      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.trigger = 1'b0;
        bus.clk_en  = 1'b0;
        for (int i = 0; i < v.len; i++) begin
            e = {v.p1[v.len-1-i], v.p0[v.len-1-i], 2'b00};
            for (int p = 0; p < period; p++) begin
                push_and_check($sformatf("%s_p%0d_t%0d", v.name, period, i), e);
                if (trig_mid && p == period - 1 && (i == v.len / 2 || i == v.len - 1)) begin
                    bus.trigger     = 1'b1;
                    bus.pulse_num   = {16'd7, 16'd7};
                    bus.pulse_width = 8'd5;
                    bus.mode        = ~v.md;
                end
                bus.clk_en = (p == period - 1);
                @(posedge clk);
                @(negedge clk);
                bus.clk_en  = 1'b0;
                bus.trigger = 1'b0;
            end
        end
        push_and_check($sformatf("%s_p%0d_end", v.name, period), 4'b0011);
        bus.pulse_num   = {v.k1, v.k0};
        bus.pulse_width = v.w;
        bus.mode        = v.md;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_vec(0, "ind_w2_3_1",  16'd3, 16'd1, 8'd2, 1'b0, 12, 32'b110011001100, 32'b110000000000);
        set_vec(1, "syn_w1_4_2",  16'd4, 16'd2, 8'd1, 1'b1, 8,  32'b10101010,     32'b00100010);
        set_vec(2, "syn_w1_5_3",  16'd5, 16'd3, 8'd1, 1'b1, 10, 32'b1010101010,   32'b0010001010);
        set_vec(3, "zero_cnt",    16'd0, 16'd0, 8'd3, 1'b0, 1,  32'b0,            32'b0);
        set_vec(4, "zero_w",      16'd4, 16'd4, 8'd0, 1'b1, 1,  32'b0,            32'b0);
        set_vec(5, "ind_w1_2_3",  16'd2, 16'd3, 8'd1, 1'b0, 6,  32'b101000,       32'b101010);
        set_vec(6, "syn_w3_2_2",  16'd2, 16'd2, 8'd3, 1'b1, 12, 32'b111000111000, 32'b111000111000);
        set_vec(7, "syn_w1_1_3",  16'd1, 16'd3, 8'd1, 1'b1, 6,  32'b000010,       32'b101010);
        set_vec(8, "ind_w1_1_3",  16'd1, 16'd3, 8'd1, 1'b0, 6,  32'b100000,       32'b101010);

        reset           = 1'b1;
        bus.clk_en      = 1'b0;
        bus.trigger     = 1'b0;
        bus.mode        = 1'b0;
        bus.pulse_num   = '0;
        bus.pulse_width = '0;
        #12;
        check("reset_state", sample(), 4'b0001);
        @(negedge clk);
        reset = 1'b0;
        push_and_check("idle_after_reset", 4'b0001);

        for (int i = 0; i < 9; i++) run_vec(i, 1, 1'b0);
        run_vec(0, 3, 1'b0);
        run_vec(2, 3, 1'b0);
        run_vec(0, 1, 1'b1);
        run_vec(1, 1, 1'b1);

        // Reset asserted between edges while both outputs are high.
        bus.pulse_num   = {16'd1, 16'd3};
        bus.pulse_width = 8'd2;
        bus.mode        = 1'b0;
        bus.trigger     = 1'b1;
        bus.clk_en      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.trigger = 1'b0;
        check("pre_reset_pulse", sample(), 4'b1100);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_now", sample(), 4'b0001);
        @(negedge clk);
        reset = 1'b0;
        bus.clk_en = 1'b0;
        check("after_reset_idle", sample(), 4'b0001);

        run_vec(1, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
